// File: rtl/gshare_bht.sv
// Purpose: gshare taken/not-taken predictor; 2-bit counters indexed by pc ^ global history.
// Latency: zero-cycle combinational prediction; training and history updates land on the next rising edge.
// Backpressure: stall freezes only the speculative history shift; training and repair proceed regardless.
//
// Ports:
//   clk, rst_n         clock and asynchronous active-low reset
//   pc, btb_hit, stall fetch-side lookup; a hit with no stall shifts the prediction into the history
//   predict_taken      MSB of the selected counter
//   ghr_snapshot       history used for this prediction, carried to EX with the branch
//   update_*           EX resolution: trains a counter, and on mispredict rebuilds the history
//   mispredict         only meaningful when update_valid is set
module gshare_bht #(
    parameter int PC_WIDTH    = 13,
    parameter int INDEX_WIDTH = 6,
    parameter int GHR_WIDTH   = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [PC_WIDTH-1:0]    pc,
    input  logic                   btb_hit,
    input  logic                   stall,
    output logic                   predict_taken,
    output logic [GHR_WIDTH-1:0]   ghr_snapshot,
    input  logic                   update_valid,
    input  logic [PC_WIDTH-1:0]    update_pc,
    input  logic [GHR_WIDTH-1:0]   update_ghr,
    input  logic                   update_taken,
    input  logic                   mispredict
);

    localparam int NUM_CNT = 1 << INDEX_WIDTH;

    logic [1:0]             cnt_q [NUM_CNT];
    logic [1:0]             cnt_d [NUM_CNT];
    logic [GHR_WIDTH-1:0]   ghr_q;
    logic [GHR_WIDTH-1:0]   ghr_d;

    logic [INDEX_WIDTH-1:0] ghr_ext;
    logic [INDEX_WIDTH-1:0] upd_ghr_ext;
    logic [INDEX_WIDTH-1:0] pidx;
    logic [INDEX_WIDTH-1:0] uidx;

    // Only the low INDEX_WIDTH bits of each pc feed the hash.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pc, update_pc};

    // History is zero-extended to the index width before hashing.
    always_comb begin
        ghr_ext                       = '0;
        ghr_ext[GHR_WIDTH-1:0]        = ghr_q;
        upd_ghr_ext                   = '0;
        upd_ghr_ext[GHR_WIDTH-1:0]    = update_ghr;
        pidx = pc[INDEX_WIDTH-1:0] ^ ghr_ext;
        uidx = update_pc[INDEX_WIDTH-1:0] ^ upd_ghr_ext;
    end

    // Read uses the registered counter, so a same-cycle update to the same
    // index is only visible from the following cycle.
    assign predict_taken = cnt_q[pidx][1];
    assign ghr_snapshot  = ghr_q;

    // Counter training: saturating increment/decrement at the resolved index.
    always_comb begin
        cnt_d = cnt_q;
        if (update_valid) begin
            if (update_taken) begin
                if (cnt_q[uidx] != 2'b11) begin
                    cnt_d[uidx] = cnt_q[uidx] + 2'd1;
                end
            end else begin
                if (cnt_q[uidx] != 2'b00) begin
                    cnt_d[uidx] = cnt_q[uidx] - 2'd1;
                end
            end
        end
    end

    // History: mispredict repair rebuilds from the branch's own snapshot,
    // discarding any younger speculative bits including this cycle's shift.
    always_comb begin
        ghr_d = ghr_q;
        if (update_valid && mispredict) begin
            ghr_d = {update_ghr[GHR_WIDTH-2:0], update_taken};
        end else if (btb_hit && !stall) begin
            ghr_d = {ghr_q[GHR_WIDTH-2:0], predict_taken};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr_q <= '0;
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt_q[i] <= 2'b01;
            end
        end else begin
            ghr_q <= ghr_d;
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

endmodule
